// File: rtl/alu_result_select_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// alu_result_select_if : input beat / output beat bus of alu_result_select
// Revision 1.0
// ----------------------------------------------------------------------------
interface alu_result_select_if #(
  parameter int WIDTH      = 24,
  parameter int NUM_INPUTS = 4,
  parameter int SEL_WIDTH  = 3,
  parameter int ERR_CNT_W  = 8
);
  logic [NUM_INPUTS*WIDTH-1:0] in_data;
  logic [SEL_WIDTH-1:0]        selector;
  logic                        in_valid;
  logic                        in_ready;
  logic [WIDTH-1:0]            out_data;
  logic                        out_zero;
  logic                        out_selerr;
  logic                        out_valid;
  logic                        out_ready;
  logic [ERR_CNT_W-1:0]        err_count;

  modport master (
    output in_data, selector, in_valid, out_ready,
    input  in_ready, out_data, out_zero, out_selerr, out_valid, err_count
  );

  modport slave (
    input  in_data, selector, in_valid, out_ready,
    output in_ready, out_data, out_zero, out_selerr, out_valid, err_count
  );
endinterface
`default_nettype wire

// File: rtl/alu_result_select.sv
`default_nettype none
// ----------------------------------------------------------------------------
// alu_result_select : N-to-1 result selector feeding a 2-entry skid buffer
// Revision 1.0
// ----------------------------------------------------------------------------
module alu_result_select #(
  parameter int WIDTH      = 24,
  parameter int NUM_INPUTS = 4,
  parameter int SEL_WIDTH  = 3,
  parameter int ERR_CNT_W  = 8
) (
  input  wire logic            clk_i,
  input  wire logic            rst_i,
  alu_result_select_if.slave   bus_io
);

  // Beat layout: {selerr, zero, data}
  localparam int                BEAT_W   = WIDTH + 2;
  localparam logic [BEAT_W-1:0] RST_BEAT = {1'b0, 1'b1, {WIDTH{1'b0}}};

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL1 = 2'd1,
    ST_FULL2 = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [BEAT_W-1:0]    main_q, main_d;
  logic [BEAT_W-1:0]    skid_q, skid_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic [WIDTH-1:0]     w_sel_data;
  logic                 w_sel_err;
  logic [BEAT_W-1:0]    w_new_beat;
  logic                 w_accept;

  always_comb begin
    w_sel_data = '0;
    w_sel_err  = 1'b1;
    for (int k = 0; k < NUM_INPUTS; k++) begin
      if (bus_io.selector == SEL_WIDTH'(k)) begin
        w_sel_data = bus_io.in_data[k*WIDTH +: WIDTH];
        w_sel_err  = 1'b0;
      end
    end
  end

  assign w_new_beat = {w_sel_err, (w_sel_data == '0), w_sel_data};

  // Ready comes from registered state only, so no path from out_ready
  assign bus_io.in_ready   = (state_q != ST_FULL2);
  assign bus_io.out_valid  = (state_q != ST_EMPTY);
  assign bus_io.out_data   = main_q[WIDTH-1:0];
  assign bus_io.out_zero   = main_q[WIDTH];
  assign bus_io.out_selerr = main_q[WIDTH+1];
  assign bus_io.err_count  = err_cnt_q;

  assign w_accept = bus_io.in_valid && bus_io.in_ready;

  always_comb begin
    state_d   = state_q;
    main_d    = main_q;
    skid_d    = skid_q;
    err_cnt_d = err_cnt_q;
    case (state_q)
      ST_EMPTY: begin
        if (w_accept) begin
          main_d  = w_new_beat;
          state_d = ST_FULL1;
        end
      end
      ST_FULL1: begin
        if (w_accept && bus_io.out_ready) begin
          main_d = w_new_beat;
        end else if (w_accept) begin
          skid_d  = w_new_beat;
          state_d = ST_FULL2;
        end else if (bus_io.out_ready) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL2: begin
        if (bus_io.out_ready) begin
          main_d  = skid_q;
          state_d = ST_FULL1;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    if (w_accept && w_sel_err && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_EMPTY;
      main_q    <= RST_BEAT;
      skid_q    <= RST_BEAT;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      main_q    <= main_d;
      skid_q    <= skid_d;
      err_cnt_q <= err_cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_result_select.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_alu_result_select : directed + random bench with a queue-based reference
// Revision 1.0
// ----------------------------------------------------------------------------
module tb_alu_result_select;
  localparam int W  = 24;
  localparam int N  = 4;
  localparam int SW = 3;
  localparam int EW = 8;
  localparam int EMAX = (1 << EW) - 1;

  typedef struct {
    logic [W-1:0] data;
    logic         zero;
    logic         err;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   pass_cnt  = 0;
  int   total_cnt = 0;
  int   errm      = 0;
  beat_t q[$];

  alu_result_select_if #(.WIDTH(W), .NUM_INPUTS(N), .SEL_WIDTH(SW), .ERR_CNT_W(EW)) res_if ();

  alu_result_select #(.WIDTH(W), .NUM_INPUTS(N), .SEL_WIDTH(SW), .ERR_CNT_W(EW)) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .bus_io (res_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic beat_t ref_beat(input logic [SW-1:0] s, input logic [N*W-1:0] d);
    beat_t r;
    if (int'(s) < N) begin
      r.data = W'(d >> (int'(s) * W));
      r.err  = 1'b0;
    end else begin
      r.data = '0;
      r.err  = 1'b1;
    end
    r.zero = (r.data == 0);
    return r;
  endfunction

  // Called just after a falling edge; returns just after the next falling edge.
  task automatic cyc(input bit v, input logic [SW-1:0] s, input logic [N*W-1:0] d, input bit ordy);
    logic  rdy_before;
    bit    acc, fire;
    beat_t nb;
    rdy_before         = res_if.in_ready;
    res_if.in_valid    = v;
    res_if.selector    = s;
    res_if.in_data     = d;
    res_if.out_ready   = ordy;
    #1;
    chk("rdy_indep", 32'(res_if.in_ready), 32'(rdy_before));
    chk("in_ready", 32'(res_if.in_ready), 32'(q.size() < 2));
    chk("out_valid", 32'(res_if.out_valid), 32'(q.size() > 0));
    chk("err_count", 32'(res_if.err_count), 32'(errm));
    if (q.size() > 0) begin
      chk("out_data", 32'(res_if.out_data), 32'(q[0].data));
      chk("out_zero", 32'(res_if.out_zero), 32'(q[0].zero));
      chk("out_selerr", 32'(res_if.out_selerr), 32'(q[0].err));
    end
    acc  = v && (q.size() < 2);
    fire = (q.size() > 0) && ordy;
    @(posedge clk);
    if (fire) void'(q.pop_front());
    if (acc) begin
      nb = ref_beat(s, d);
      q.push_back(nb);
      if (nb.err && errm < EMAX) errm++;
    end
    @(negedge clk);
  endtask

  function automatic logic [N*W-1:0] rnd_data();
    logic [N*W-1:0] d;
    d = {$urandom, $urandom, $urandom};
    if ($urandom_range(0, 3) == 0) d[$urandom_range(0, N-1)*W +: W] = '0;
    return d;
  endfunction

  logic [N*W-1:0] vec;

  initial begin
    res_if.in_valid  = 1'b0;
    res_if.selector  = '0;
    res_if.in_data   = '0;
    res_if.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(res_if.out_valid), 32'd0);
    chk("rst_in_ready", 32'(res_if.in_ready), 32'd1);
    chk("rst_out_data", 32'(res_if.out_data), 32'd0);
    chk("rst_out_zero", 32'(res_if.out_zero), 32'd1);
    chk("rst_out_selerr", 32'(res_if.out_selerr), 32'd0);
    chk("rst_err_count", 32'(res_if.err_count), 32'd0);
    rst = 1'b0;

    // Basic select of input 2
    vec = {24'h000004, 24'h000003, 24'h000002, 24'h000001};
    cyc(1'b1, 3'd2, vec, 1'b1);
    chk("t1_data", 32'(res_if.out_data), 32'h000003);
    chk("t1_valid", 32'(res_if.out_valid), 32'd1);
    chk("t1_zero", 32'(res_if.out_zero), 32'd0);

    // Zero-valued in-range input
    vec = {24'h000000, 24'h000003, 24'h000002, 24'h000001};
    cyc(1'b1, 3'd3, vec, 1'b1);
    chk("t2_data", 32'(res_if.out_data), 32'd0);
    chk("t2_zero", 32'(res_if.out_zero), 32'd1);
    chk("t2_selerr", 32'(res_if.out_selerr), 32'd0);
    chk("t2_errcnt", 32'(res_if.err_count), 32'd0);

    // Out-of-range select and counter saturation
    cyc(1'b1, 3'd5, rnd_data(), 1'b1);
    chk("t3_data", 32'(res_if.out_data), 32'd0);
    chk("t3_selerr", 32'(res_if.out_selerr), 32'd1);
    chk("t3_zero", 32'(res_if.out_zero), 32'd1);
    chk("t3_errcnt1", 32'(res_if.err_count), 32'd1);
    for (int i = 0; i < 299; i++) cyc(1'b1, 3'd5, rnd_data(), 1'b1);
    chk("t3_errsat", 32'(res_if.err_count), 32'd255);
    cyc(1'b0, 'x, 'x, 1'b1);

    // Stall: two beats fill main and skid
    cyc(1'b1, 3'd0, {72'h0, 24'h111111}, 1'b0);
    cyc(1'b1, 3'd0, {72'h0, 24'h222222}, 1'b0);
    chk("t4_full_rdy", 32'(res_if.in_ready), 32'd0);
    chk("t4_hold_a", 32'(res_if.out_data), 32'h111111);
    cyc(1'b0, 'x, 'x, 1'b0);
    chk("t4_stable_a", 32'(res_if.out_data), 32'h111111);
    cyc(1'b0, 'x, 'x, 1'b1);
    chk("t4_then_b", 32'(res_if.out_data), 32'h222222);
    chk("t4_rdy_back", 32'(res_if.in_ready), 32'd1);
    cyc(1'b0, 'x, 'x, 1'b1);
    chk("t4_drained", 32'(res_if.out_valid), 32'd0);

    // Random traffic with random backpressure
    for (int i = 0; i < 100; i++)
      cyc(1'b1, SW'($urandom_range(0, 7)), rnd_data(), 1'($urandom_range(0, 1)));
    for (int i = 0; i < 4; i++) cyc(1'b0, 'x, 'x, 1'b1);
    chk("t5_drained", 32'(q.size()), 32'd0);

    // Asynchronous reset while both entries are full
    cyc(1'b1, 3'd1, rnd_data(), 1'b0);
    cyc(1'b1, 3'd6, rnd_data(), 1'b0);
    chk("t6_pre_full", 32'(res_if.in_ready), 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("t6_valid", 32'(res_if.out_valid), 32'd0);
    chk("t6_ready", 32'(res_if.in_ready), 32'd1);
    chk("t6_errcnt", 32'(res_if.err_count), 32'd0);
    chk("t6_zero", 32'(res_if.out_zero), 32'd1);
    q.delete();
    errm = 0;
    @(negedge clk);
    rst = 1'b0;
    vec = rnd_data();
    cyc(1'b1, 3'd1, vec, 1'b1);
    chk("t6_after", 32'(res_if.out_data), 32'(vec[W +: W]));
    cyc(1'b0, 'x, 'x, 1'b1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
`default_nettype wire
